// File: rtl/aha_sif_axi_pkg.sv
// Shared constants for the SIF <-> AXI bridges: FSM state encodings and fixed AXI field values.
package aha_sif_axi_pkg;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWrReq  = 3'd1;
    localparam logic [2:0] StWrResp = 3'd2;
    localparam logic [2:0] StRdReq  = 3'd3;
    localparam logic [2:0] StRdResp = 3'd4;

    localparam logic [1:0] BURST_INCR                  = 2'b01;
    localparam logic [2:0] SIZE_8B                     = 3'd3;
    localparam logic [3:0] CACHE_BUFFERABLE_MODIFIABLE = 4'b0011;
    localparam logic [1:0] RESP_OKAY                   = 2'b00;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/aha_sif_rr_arbiter.sv
// Two-way round-robin request arbiter between a SIF write and a SIF read requester.
module aha_sif_rr_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    output logic wr_rdy_o,
    output logic rd_rdy_o
);

    logic prio_wr_q, prio_wr_d;

    always_comb begin
        wr_rdy_o  = en_i & (!rd_req_i | prio_wr_q);
        rd_rdy_o  = en_i & (!wr_req_i | !prio_wr_q);
        prio_wr_d = prio_wr_q;
        // Priority only moves when a grant was actually contended.
        if (en_i & wr_req_i & rd_req_i) begin
            prio_wr_d = !prio_wr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_wr_q <= 1'b1;
        end else begin
            prio_wr_q <= prio_wr_d;
        end
    end

endmodule

// File: rtl/aha_sif_to_axi_master.sv
// SIF requester to single-beat AXI4 master bridge, one transaction outstanding.
// Optional AHA_SIF2AXI_ERR_ADDR_EN adds ERR_ADDR/ERR_IS_WR capture of the first error.
module aha_sif_to_axi_master
    import aha_sif_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SIF_WR_EN,
    output logic                  SIF_WR_READY,
    input  logic [ADDR_WIDTH-1:0] SIF_WR_ADDR,
    input  logic [63:0]           SIF_WR_DATA,
    input  logic [7:0]            SIF_WR_STRB,
    output logic                  SIF_WR_DONE,
    input  logic                  SIF_RD_EN,
    output logic                  SIF_RD_READY,
    input  logic [ADDR_WIDTH-1:0] SIF_RD_ADDR,
    output logic [63:0]           SIF_RD_DATA,
    output logic                  SIF_RD_VALID,
    output logic                  ERR,
`ifdef AHA_SIF2AXI_ERR_ADDR_EN
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_IS_WR,
`endif
    input  logic                  ERR_CLR,
    output logic [ID_WIDTH-1:0]   AWID,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWLOCK,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [63:0]           WDATA,
    output logic [7:0]            WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [ID_WIDTH-1:0]   BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARLOCK,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic [63:0]           RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [63:0]           wdata_q, wdata_d;
    logic [7:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [63:0]           rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q, err_d;
    logic                  new_err;
    logic                  wr_rdy, rd_rdy;
    logic                  unused_axi_in;

    assign unused_axi_in = ^{BID, RID, RLAST};

    // Readies are held low during reset so nothing is accepted while RESET is high.
    aha_sif_rr_arbiter u_arb (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .en_i     ((state_q == StIdle) & !RESET),
        .wr_req_i (SIF_WR_EN),
        .rd_req_i (SIF_RD_EN),
        .wr_rdy_o (wr_rdy),
        .rd_rdy_o (rd_rdy)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        new_err    = 1'b0;
        case (state_q)
            StIdle: begin
                if (SIF_WR_EN & wr_rdy) begin
                    addr_d    = SIF_WR_ADDR;
                    wdata_d   = SIF_WR_DATA;
                    wstrb_d   = SIF_WR_STRB;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWrReq;
                end else if (SIF_RD_EN & rd_rdy) begin
                    addr_d    = SIF_RD_ADDR;
                    arvalid_d = 1'b1;
                    state_d   = StRdReq;
                end
            end
            StWrReq: begin
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY) wvalid_d = 1'b0;
                if ((!awvalid_q | AWREADY) & (!wvalid_q | WREADY)) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (BVALID) begin
                    new_err = resp_is_err(BRESP);
                    state_d = StIdle;
                end
            end
            StRdReq: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdResp;
                end
            end
            StRdResp: begin
                if (RVALID) begin
                    rd_data_d  = RDATA;
                    rd_valid_d = 1'b1;
                    new_err    = resp_is_err(RRESP);
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new error beats a simultaneous clear.
        err_d = new_err | (err_q & !ERR_CLR);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

`ifdef AHA_SIF2AXI_ERR_ADDR_EN
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  err_is_wr_q, err_is_wr_d;

    always_comb begin
        err_addr_d  = err_addr_q;
        err_is_wr_d = err_is_wr_q;
        if (ERR_CLR) begin
            err_addr_d  = '0;
            err_is_wr_d = 1'b0;
        end
        // A clear in the same cycle re-arms capture for the incoming error.
        if (new_err & (!err_q | ERR_CLR)) begin
            err_addr_d  = addr_q;
            err_is_wr_d = (state_q == StWrResp);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_addr_q  <= '0;
            err_is_wr_q <= 1'b0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_is_wr_q <= err_is_wr_d;
        end
    end

    assign ERR_ADDR  = err_addr_q;
    assign ERR_IS_WR = err_is_wr_q;
`endif

    assign SIF_WR_READY = wr_rdy;
    assign SIF_RD_READY = rd_rdy;
    assign SIF_WR_DONE  = (state_q == StWrResp) & BVALID;
    assign SIF_RD_DATA  = rd_data_q;
    assign SIF_RD_VALID = rd_valid_q;
    assign ERR          = err_q;

    assign AWID    = ID_WIDTH'(AXI_ID);
    assign AWADDR  = addr_q;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = SIZE_8B;
    assign AWBURST = BURST_INCR;
    assign AWLOCK  = 1'b0;
    assign AWCACHE = CACHE_BUFFERABLE_MODIFIABLE;
    assign AWPROT  = 3'b000;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;
    assign BREADY  = (state_q == StWrResp);

    assign ARID    = ID_WIDTH'(AXI_ID);
    assign ARADDR  = addr_q;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = SIZE_8B;
    assign ARBURST = BURST_INCR;
    assign ARLOCK  = 1'b0;
    assign ARCACHE = CACHE_BUFFERABLE_MODIFIABLE;
    assign ARPROT  = 3'b000;
    assign ARVALID = arvalid_q;
    assign RREADY  = (state_q == StRdResp);

endmodule
